// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants and state type for the fetch PC generator.
// Parameter defaults of fetch_pc_gen are taken from here.
package fetch_pc_gen_pkg;

    localparam int          DEF_ADDR_W     = 32;
    localparam int          DEF_FETCH_W    = 2;
    localparam int          DEF_INST_BYTES = 4;
    localparam logic [31:0] DEF_RESET_PC   = 32'h1c00_0000;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection: exception > branch redirect > sequential advance > hold.
// Redirect targets are forced onto an instruction boundary.
module fetch_pc_next #(
    parameter int ADDR_W      = 32,
    parameter int INST_BYTES  = 4,
    parameter int GROUP_BYTES = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              fire,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              excp_en,
    input  logic [ADDR_W-1:0] excp_pc,
    output logic [ADDR_W-1:0] next_pc
);

    localparam logic [ADDR_W-1:0] INST_MASK  = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] GROUP_MASK = ADDR_W'(GROUP_BYTES - 1);
    localparam logic [ADDR_W-1:0] GROUP_STEP = ADDR_W'(GROUP_BYTES);

    always_comb begin
        next_pc = pc;
        if (excp_en) begin
            next_pc = excp_pc & ~INST_MASK;
        end else if (redirect_en) begin
            next_pc = redirect_pc & ~INST_MASK;
        end else if (fire) begin
            // Sequential fetch always lands on the next group boundary; wraps modulo 2^ADDR_W.
            next_pc = (pc & ~GROUP_MASK) + GROUP_STEP;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: BOOT/RUN state, registered fetch PC, request valid and slot mask.
// Request handshake: a fetch group transfers (fire) on a cycle where inst_en_o & ready_i & ~stall_i.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
    parameter int                FETCH_W    = DEF_FETCH_W,
    parameter int                INST_BYTES = DEF_INST_BYTES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               ready_i,
    input  logic               redirect_en_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    input  logic               excp_en_i,
    input  logic [ADDR_W-1:0]  excp_pc_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               inst_en_o,
    output logic [FETCH_W-1:0] slot_mask_o
);

    localparam int GROUP_BYTES = FETCH_W * INST_BYTES;
    localparam int IB_LOG2     = $clog2(INST_BYTES);

    pc_state_e          state_q;
    pc_state_e          state_d;
    logic               run;
    logic               fire;
    logic               inst_en_d;
    logic [ADDR_W-1:0]  pc_d;
    logic [ADDR_W-1:0]  slot_idx;
    logic [FETCH_W-1:0] mask_d;

    assign run  = (state_q == ST_RUN);
    assign fire = inst_en_o & ready_i & ~stall_i;

    always_comb begin
        state_d   = state_q;
        inst_en_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d   = ST_RUN;
                inst_en_d = 1'b1;
            end
            ST_RUN: begin
                inst_en_d = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Redirects are only honoured once running; in BOOT the PC stays at RESET_PC.
    fetch_pc_next #(
        .ADDR_W      (ADDR_W),
        .INST_BYTES  (INST_BYTES),
        .GROUP_BYTES (GROUP_BYTES)
    ) u_next (
        .pc          (pc_o),
        .fire        (fire),
        .redirect_en (redirect_en_i & run),
        .redirect_pc (redirect_pc_i),
        .excp_en     (excp_en_i & run),
        .excp_pc     (excp_pc_i),
        .next_pc     (pc_d)
    );

    // Slot index of the entry instruction within its group; earlier slots are invalid.
    assign slot_idx = (pc_d >> IB_LOG2) & ADDR_W'(FETCH_W - 1);

    always_comb begin
        mask_d = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            mask_d[i] = inst_en_d && (ADDR_W'(i) >= slot_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_o        <= RESET_PC;
            inst_en_o   <= 1'b0;
            slot_mask_o <= '0;
        end else begin
            state_q     <= state_d;
            pc_o        <= pc_d;
            inst_en_o   <= inst_en_d;
            slot_mask_o <= mask_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: reference model from the fetch rules, per-cycle compare,
// directed scenarios with literal expectations, then a short randomized stretch.
module tb_fetch_pc_gen;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        ready_i;
    logic        redirect_en_i;
    logic [31:0] redirect_pc_i;
    logic        excp_en_i;
    logic [31:0] excp_pc_i;
    logic [31:0] pc_o;
    logic        inst_en_o;
    logic [1:0]  slot_mask_o;

    int n_pass  = 0;
    int n_total = 0;

    fetch_pc_gen dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .ready_i       (ready_i),
        .redirect_en_i (redirect_en_i),
        .redirect_pc_i (redirect_pc_i),
        .excp_en_i     (excp_en_i),
        .excp_pc_i     (excp_pc_i),
        .pc_o          (pc_o),
        .inst_en_o     (inst_en_o),
        .slot_mask_o   (slot_mask_o)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // reference model: 8-byte groups of two 4-byte instructions
    logic [31:0] m_pc;
    logic        m_en;
    logic        m_boot;
    logic        m_valid = 1'b0;

    function automatic logic [1:0] exp_mask(input logic en, input logic [31:0] pc);
        int slot;
        logic [1:0] m;
        slot = int'((pc % 8) / 4);
        m = 2'b00;
        for (int i = 0; i < 2; i++) if (en && i >= slot) m[i] = 1'b1;
        return m;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pc    = RST_PC;
            m_en    = 1'b0;
            m_boot  = 1'b1;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_boot) begin
                m_boot = 1'b0;
                m_en   = 1'b1;
            end else if (excp_en_i) begin
                m_pc = excp_pc_i - (excp_pc_i % 4);
            end else if (redirect_en_i) begin
                m_pc = redirect_pc_i - (redirect_pc_i % 4);
            end else if (m_en && ready_i && !stall_i) begin
                m_pc = (m_pc / 8) * 8 + 32'd8;
            end
        end
    end

    // scoreboard check
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pc", pc_o, m_pc);
            check("model_en", {31'd0, inst_en_o}, {31'd0, m_en});
            check("model_mask", {30'd0, slot_mask_o}, {30'd0, exp_mask(m_en, m_pc)});
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic en, input logic [31:0] pc,
                              input logic [1:0] mask);
        check({tag, "_en"}, {31'd0, inst_en_o}, {31'd0, en});
        check({tag, "_pc"}, pc_o, pc);
        check({tag, "_mask"}, {30'd0, slot_mask_o}, {30'd0, mask});
    endtask

    task automatic idle_inputs();
        stall_i       = 1'b0;
        ready_i       = 1'b1;
        redirect_en_i = 1'b0;
        redirect_pc_i = '0;
        excp_en_i     = 1'b0;
        excp_pc_i     = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (3) step();
        rst = 1'b0;
        expect_out("boot", 1'b0, RST_PC, 2'b00);
        step(); expect_out("first", 1'b1, 32'h1c00_0000, 2'b11);
        step(); expect_out("seq1", 1'b1, 32'h1c00_0008, 2'b11);

        ready_i = 1'b0;
        repeat (3) begin
            step(); expect_out("notready", 1'b1, 32'h1c00_0008, 2'b11);
        end
        ready_i = 1'b1; stall_i = 1'b1;
        step(); expect_out("stall", 1'b1, 32'h1c00_0008, 2'b11);
        stall_i = 1'b0;
        step(); expect_out("seq2", 1'b1, 32'h1c00_0010, 2'b11);

        // branch redirect while icache not ready still takes effect
        ready_i = 1'b0; redirect_en_i = 1'b1; redirect_pc_i = 32'h1c00_0106;
        step(); expect_out("redir", 1'b1, 32'h1c00_0104, 2'b10);
        redirect_en_i = 1'b0; ready_i = 1'b1;
        step(); expect_out("redir_fire", 1'b1, 32'h1c00_0108, 2'b11);

        // exception beats redirect and stall
        excp_en_i = 1'b1; excp_pc_i = 32'h1c00_8000;
        redirect_en_i = 1'b1; redirect_pc_i = 32'h1c00_0200; stall_i = 1'b1;
        step(); expect_out("excp", 1'b1, 32'h1c00_8000, 2'b11);
        excp_pc_i = 32'h1c00_800f; redirect_en_i = 1'b0;
        step(); expect_out("excp_align", 1'b1, 32'h1c00_800c, 2'b10);
        idle_inputs();
        step(); expect_out("excp_fire", 1'b1, 32'h1c00_8010, 2'b11);

        // wrap past the top of the address space
        redirect_en_i = 1'b1; redirect_pc_i = 32'hffff_fff8;
        step(); expect_out("top", 1'b1, 32'hffff_fff8, 2'b11);
        redirect_en_i = 1'b0;
        step(); expect_out("wrap", 1'b1, 32'h0000_0000, 2'b11);
        redirect_en_i = 1'b1; redirect_pc_i = 32'hffff_fffd;
        step(); expect_out("top_hi", 1'b1, 32'hffff_fffc, 2'b10);
        redirect_en_i = 1'b0;
        step(); expect_out("wrap_hi", 1'b1, 32'h0000_0000, 2'b11);

        // reset mid-operation with a pending request, then redirect in BOOT ignored
        redirect_en_i = 1'b1; redirect_pc_i = 32'h1c00_0040;
        step(); expect_out("pre_rst", 1'b1, 32'h1c00_0040, 2'b11);
        redirect_en_i = 1'b0; ready_i = 1'b0; rst = 1'b1;
        step(); expect_out("mid_rst", 1'b0, RST_PC, 2'b00);
        rst = 1'b0; redirect_en_i = 1'b1; redirect_pc_i = 32'h1c00_0300;
        step(); expect_out("boot_ign", 1'b1, RST_PC, 2'b11);
        step(); expect_out("post_boot", 1'b1, 32'h1c00_0300, 2'b11);
        idle_inputs();

        // randomized stretch, checked by the model only
        for (int k = 0; k < 60; k++) begin
            rst           = ($urandom_range(0, 29) == 0);
            stall_i       = ($urandom_range(0, 3) == 0);
            ready_i       = ($urandom_range(0, 3) != 0);
            redirect_en_i = ($urandom_range(0, 5) == 0);
            redirect_pc_i = $urandom;
            excp_en_i     = ($urandom_range(0, 9) == 0);
            excp_pc_i     = $urandom;
            step();
        end
        rst = 1'b0;
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter ADDR_W, 32, PC width in bits.
REQ-002 Parameter RESET_PC, 32'h1c000000, first fetch address after reset.
REQ-003 Parameter FETCH_W, 2, instructions per fetch group; power of two, 1..8.
REQ-004 Parameter INST_BYTES, 4, bytes per instruction; GROUP_BYTES = FETCH_W*INST_BYTES.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 stall_i  in  1  backend stall; blocks sequential advance.
REQ-008 ready_i  in  1  icache accepts current fetch request.
REQ-009 redirect_en_i  in  1  branch/jump redirect request.
REQ-010 redirect_pc_i  in  ADDR_W  branch target.
REQ-011 excp_en_i  in  1  exception/ertn redirect request.
REQ-012 excp_pc_i  in  ADDR_W  exception/return target.
REQ-013 pc_o  out  ADDR_W  current fetch PC (registered).
REQ-014 inst_en_o  out  1  fetch request valid (registered).
REQ-015 slot_mask_o  out  FETCH_W  per-slot valid mask of current group (registered).

Function
REQ-016 FSM states: BOOT, RUN; BOOT -> RUN unconditionally after one cycle; RUN holds until rst.
REQ-017 BOOT: inst_en_o=0, slot_mask_o=0, pc_o=RESET_PC; redirect inputs ignored.
REQ-018 RUN: inst_en_o=1 every cycle.
REQ-019 fire = inst_en_o & ready_i & ~stall_i.
REQ-020 Priority of next-PC source: excp_en_i > redirect_en_i > fire > hold.
REQ-021 Redirects (excp or branch) in RUN take effect next cycle regardless of stall_i/ready_i.
REQ-022 Redirect target: low log2(INST_BYTES) bits forced to zero before loading pc_o.
REQ-023 On fire without redirect: pc_o <= (pc_o & ~(GROUP_BYTES-1)) + GROUP_BYTES.
REQ-024 No fire, no redirect: pc_o, slot_mask_o hold.
REQ-025 slot_mask_o bit i = 1 iff i >= pc_o[log2(GROUP_BYTES)-1:log2(INST_BYTES)] while inst_en_o=1; else 0.
REQ-026 PC arithmetic modulo 2^ADDR_W; increment past top wraps to 0 silently.
REQ-027 Latency: redirect request at cycle N -> new pc_o visible at cycle N+1.

Reset
REQ-028 rst=1 at any edge: state<=BOOT, pc_o<=RESET_PC, inst_en_o<=0, slot_mask_o<=0, overriding all other inputs.
REQ-029 Reset mid-operation (any state, any handshake status) discards pending fetch; no partial state kept.

Structure
REQ-030 Shared package holds RESET_PC, INST_BYTES, default ADDR_W/FETCH_W constants and the BOOT/RUN state enum.
REQ-031 Next-PC selection may be split into one combinational sub-module fetch_pc_next; state, registers, mask stay in fetch_pc_gen.

Verification (FETCH_W=2, defaults otherwise)
REQ-032 rst high 3 cycles, release, ready_i=1 -> cycle0 inst_en_o=0 pc_o=1c000000; cycle1 inst_en_o=1 pc_o=1c000000 mask=2'b11; then 1c000008, 1c000010.
REQ-033 At pc_o=1c000008, ready_i=0 three cycles (or stall_i=1) -> pc_o held 1c000008, inst_en_o=1, mask 2'b11.
REQ-034 redirect_en_i=1 redirect_pc_i=1c000106 -> next cycle pc_o=1c000104 mask=2'b10; after fire pc_o=1c000108 mask=2'b11.
REQ-035 excp_en_i=1 excp_pc_i=1c008000 with redirect_en_i=1 redirect_pc_i=1c000200 and stall_i=1 -> next cycle pc_o=1c008000.
REQ-036 redirect to fffffff8 then fire -> pc_o=00000000 mask=2'b11.
REQ-037 rst=1 while ready_i=0 at pc_o=1c000040 -> next cycle pc_o=1c000000 inst_en_o=0; redirect_en_i asserted that BOOT cycle ignored.
